wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and a 2-entry
// result buffer fed by the multi-cycle unit, with starvation forcing.
//
// Ports:
//   clk_i, rst_n                  clock, async active-low reset
//   RegWrite_WB/RDaddr_WB/WBdata_WB  pipeline WB write request
//   mc_valid/mc_addr/mc_data      multi-cycle result offer
//   mc_ready                      buffer accepts a result this cycle
//   rf_we/rf_waddr/rf_wdata       register-file write port
//   hold_o                        WB write refused, MEM/WB must hold
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        RegWrite_WB,
   input  logic [2:0]  RDaddr_WB,
   input  logic [15:0] WBdata_WB,
   input  logic        mc_valid,
   input  logic [2:0]  mc_addr,
   input  logic [15:0] mc_data,
   output logic        mc_ready,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic        hold_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic        r_live [2];
   logic [2:0]  r_addr [2];
   logic [15:0] r_data [2];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_cnt;
   logic [2:0]  r_starve;

   logic w_head_vld;
   logic w_head_live;
   logic w_force;
   logic w_pipe;
   logic w_pop;
   logic w_head_wr;
   logic w_push;

   assign w_head_vld  = (r_cnt != 2'd0);
   assign w_head_live = r_live[r_rd_ptr];

   assign w_force = rst_n && w_head_vld && w_head_live
                    && ({1'b0, r_starve} >= LIMIT);

   assign w_pipe = rst_n && !w_force && RegWrite_WB;

   // A dead head is dropped alongside a pipeline write.
   assign w_pop = rst_n && w_head_vld
                  && (w_force || !RegWrite_WB || !w_head_live);

   assign w_head_wr = w_pop && w_head_live;

   // Ready from registered occupancy only: no push into a full
   // buffer even if it pops this cycle.
   assign mc_ready = rst_n && (r_cnt != 2'd2);
   assign w_push   = mc_valid && mc_ready;
   assign hold_o   = w_force && RegWrite_WB;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 3'd0;
      rf_wdata = 16'd0;
      if (w_head_wr) begin
         rf_we    = 1'b1;
         rf_waddr = r_addr[r_rd_ptr];
         rf_wdata = r_data[r_rd_ptr];
      end else if (w_pipe) begin
         rf_we    = 1'b1;
         rf_waddr = RDaddr_WB;
         rf_wdata = WBdata_WB;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_live[i] <= 1'b0;
            r_addr[i] <= 3'd0;
            r_data[i] <= 16'd0;
         end
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_cnt    <= 2'd0;
         r_starve <= 3'd0;
      end else begin
         // Older buffered results to the same register are stale once
         // the pipeline writes it; drop them.
         for (int i = 0; i < 2; i++) begin
            if (w_pipe && (r_addr[i] == RDaddr_WB)
                && !(w_pop && (r_rd_ptr == 1'(i))))
               r_live[i] <= 1'b0;
         end
         if (w_pop) begin
            r_live[r_rd_ptr] <= 1'b0;
            r_rd_ptr         <= ~r_rd_ptr;
         end
         if (w_push) begin
            r_live[r_wr_ptr] <= 1'b1;
            r_addr[r_wr_ptr] <= mc_addr;
            r_data[r_wr_ptr] <= mc_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_pop || (r_cnt == 2'd0))
            r_starve <= 3'd0;
         else if (w_head_live && (r_starve != 3'd7))
            r_starve <= r_starve + 3'd1;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand-written
// starvation and mid-operation reset sequences.
module tb_wb_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        RegWrite_WB;
   logic [2:0]  RDaddr_WB;
   logic [15:0] WBdata_WB;
   logic        mc_valid;
   logic [2:0]  mc_addr;
   logic [15:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        hold_o;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk_i = ~clk_i;

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .RegWrite_WB (RegWrite_WB),
      .RDaddr_WB   (RDaddr_WB),
      .WBdata_WB   (WBdata_WB),
      .mc_valid    (mc_valid),
      .mc_addr     (mc_addr),
      .mc_data     (mc_data),
      .mc_ready    (mc_ready),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .hold_o      (hold_o)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        rw;
      logic [2:0]  ra;
      logic [15:0] rd;
      logic        mv;
      logic [2:0]  ma;
      logic [15:0] md;
      logic        e_rdy;
      logic        e_we;
      logic [2:0]  e_wa;
      logic [15:0] e_wd;
      logic        e_hd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string nm, input logic rst, input logic rw,
                      input logic [2:0] ra, input logic [15:0] rd,
                      input logic mv, input logic [2:0] ma,
                      input logic [15:0] md, input logic e_rdy,
                      input logic e_we, input logic [2:0] e_wa,
                      input logic [15:0] e_wd, input logic e_hd);
      vec_t v;
      v.name = nm; v.rst = rst; v.rw = rw; v.ra = ra; v.rd = rd;
      v.mv = mv; v.ma = ma; v.md = md; v.e_rdy = e_rdy; v.e_we = e_we;
      v.e_wa = e_wa; v.e_wd = e_wd; v.e_hd = e_hd;
      vq.push_back(v);
   endtask

   // Drive one cycle's inputs, check outputs at the falling edge,
   // then advance to just after the next rising edge.
   task automatic run(input vec_t v);
      logic [21:0] got, exp;
      rst_n = v.rst; RegWrite_WB = v.rw; RDaddr_WB = v.ra;
      WBdata_WB = v.rd; mc_valid = v.mv; mc_addr = v.ma; mc_data = v.md;
      @(negedge clk_i);
      got = {mc_ready, rf_we, rf_waddr, rf_wdata, hold_o};
      exp = {v.e_rdy, v.e_we, v.e_wa, v.e_wd, v.e_hd};
      n_tot++;
      if (got === exp) n_pass++;
      else
         $display("FAIL %s: got rdy=%b we=%b wa=%0d wd=%h hd=%b, need rdy=%b we=%b wa=%0d wd=%h hd=%b",
                  v.name, got[21], got[20], got[19:17], got[16:1], got[0],
                  exp[21], exp[20], exp[19:17], exp[16:1], exp[0]);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // reset ignores inputs
      add("rst_hold", 0, 1, 2, 16'hFFFF, 1, 3, 16'h5555, 0, 0, 0, 16'h0, 0);
      add("rst_rel",  1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0, 0);
      // idle drain
      add("drn_push", 1, 0, 0, 16'h0, 1, 3, 16'h1234, 1, 0, 0, 16'h0,    0);
      add("drn_wr",   1, 0, 0, 16'h0, 0, 0, 16'h0,    1, 1, 3, 16'h1234, 0);
      add("drn_idle", 1, 0, 0, 16'h0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0);
      // pipeline priority
      add("pri_push", 1, 0, 0, 16'h0,    1, 5, 16'hAAAA, 1, 0, 0, 16'h0,    0);
      add("pri_p1",   1, 1, 2, 16'h0202, 0, 0, 16'h0,    1, 1, 2, 16'h0202, 0);
      add("pri_p2",   1, 1, 2, 16'h0202, 0, 0, 16'h0,    1, 1, 2, 16'h0202, 0);
      add("pri_p3",   1, 1, 2, 16'h0202, 0, 0, 16'h0,    1, 1, 2, 16'h0202, 0);
      add("pri_fifo", 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 1, 5, 16'hAAAA, 0);
      add("pri_idle", 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0,    0);
      // full + squash
      add("fs_push6", 1, 1, 1, 16'h1111, 1, 6, 16'h0001, 1, 1, 1, 16'h1111, 0);
      add("fs_push7", 1, 1, 1, 16'h1111, 1, 7, 16'h0002, 1, 1, 1, 16'h1111, 0);
      add("fs_full",  1, 1, 7, 16'h7777, 1, 0, 16'hDEAD, 0, 1, 7, 16'h7777, 0);
      add("fs_wr6",   1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 6, 16'h0001, 0);
      add("fs_dead7", 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0,    0);
      add("fs_empty", 1, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0,    0);
      // push and pop together at occupancy 1
      add("pp_push",  1, 0, 0, 16'h0, 1, 2, 16'h0B0B, 1, 0, 0, 16'h0,    0);
      add("pp_both",  1, 0, 0, 16'h0, 1, 3, 16'h0C0C, 1, 1, 2, 16'h0B0B, 0);
      add("pp_wr2",   1, 0, 0, 16'h0, 0, 0, 16'h0,    1, 1, 3, 16'h0C0C, 0);
      add("pp_idle",  1, 0, 0, 16'h0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0);

      // starvation: head waits 4 cycles then forces the port
      add("sv_push",  1, 1, 1, 16'h0101, 1, 4, 16'hBEEF, 1, 1, 1, 16'h0101, 0);
      for (int i = 0; i < 4; i++)
         add("sv_wait", 1, 1, 1, 16'h0101, 0, 0, 16'h0, 1, 1, 1, 16'h0101, 0);
      add("sv_force", 1, 1, 1, 16'h0101, 0, 0, 16'h0, 1, 1, 4, 16'hBEEF, 1);
      add("sv_after", 1, 1, 1, 16'h0101, 0, 0, 16'h0, 1, 1, 1, 16'h0101, 0);
      add("sv_idle",  1, 0, 0, 16'h0,    0, 0, 16'h0, 1, 0, 0, 16'h0,    0);

      // reset mid-operation with two buffered entries
      add("mr_push5", 1, 1, 1, 16'h0101, 1, 5, 16'h5555, 1, 1, 1, 16'h0101, 0);
      add("mr_push6", 1, 1, 1, 16'h0101, 1, 6, 16'h6666, 1, 1, 1, 16'h0101, 0);
      add("mr_rst",   0, 1, 1, 16'h0101, 1, 2, 16'h2222, 0, 0, 0, 16'h0,    0);
      for (int i = 0; i < 6; i++)
         add("mr_after", 1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 16'h0, 0);

      foreach (vq[i]) run(vq[i]);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
